// File: rtl/parity_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : parity_frame_rx
// Purpose  : Idle-high serial frame receiver with XOR parity check.
//            Frame = start bit, DATA_W data bits (LSB first), parity bit,
//            stop bit, each CLKS_PER_BIT clocks long.  Bits are sampled near
//            the centre of each bit period, counted from the first low
//            sample seen in IDLE.  The received word is presented with its
//            parity and framing status for one cycle per completed frame.
// Ports    : clk        - clock, all logic on rising edge
//            rst        - synchronous active-high reset
//            rx_in      - serial line, idle high, already synchronous to clk
//            data_out   - last received word, held until next frame completes
//            valid_out  - one-cycle pulse when a frame completes
//            parity_err - parity mismatch on last frame
//            frame_err  - stop bit sampled low on last frame
//            busy       - high while a frame is being received
// Revision : 1.0 - initial release
// ============================================================================
module parity_frame_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int ODD_PARITY   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    // Bit timer compares: the timer is cleared on the edge that takes a
    // sample, so a value of N-1 means N cycles have elapsed since then.
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_W - 1);
    localparam logic               c_ODD      = (ODD_PARITY != 0);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [2:0]         state_q,  state_d;
    logic [c_CNT_W-1:0] cnt_q,    cnt_d;
    logic [c_IDX_W-1:0] idx_q,    idx_d;
    logic [DATA_W-1:0]  shift_q,  shift_d;
    logic               par_q,    par_d;
    logic [DATA_W-1:0]  data_q,   data_d;
    logic               valid_q,  valid_d;
    logic               perr_q,   perr_d;
    logic               ferr_q,   ferr_d;
    logic               busy_q,   busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        busy_d  = busy_q;

        case (state_q)
            c_IDLE: begin
                if (!rx_in) begin
                    state_d = c_START;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end

            c_START: begin
                if (cnt_q == c_CNT_HALF) begin
                    cnt_d = '0;
                    if (rx_in) begin
                        // Line went back high before mid-bit: treat as a glitch.
                        state_d = c_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = c_DATA;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            c_DATA: begin
                if (cnt_q == c_CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_in;
                    if (idx_q == c_IDX_LAST) begin
                        state_d = c_PARITY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            c_PARITY: begin
                if (cnt_q == c_CNT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_in;
                    state_d = c_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            c_STOP: begin
                if (cnt_q == c_CNT_LAST) begin
                    // Word and status are published together with the pulse,
                    // so the flags always describe the word on data_out.
                    cnt_d   = '0;
                    state_d = c_IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    data_d  = shift_q;
                    perr_d  = (^shift_q) ^ par_q ^ c_ODD;
                    ferr_d  = ~rx_in;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = c_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_frame_rx
// Purpose  : Self-checking bench for parity_frame_rx.  Two receivers (even
//            and odd parity) listen to the same line; received frames are
//            compared with the transmitted words and the parity/framing
//            rules applied to what was sent.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parity_frame_rx;

    localparam int DW        = 8;
    localparam int C         = 4;
    localparam int H         = C / 2;
    localparam int FRAME     = (DW + 3) * C;
    localparam int VALID_OFS = H + (DW + 2) * C;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic [DW-1:0] data_e, data_o;
    logic          valid_e, valid_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    parity_frame_rx #(.DATA_W(DW), .CLKS_PER_BIT(C), .ODD_PARITY(0)) dut_even (
        .clk(clk), .rst(rst), .rx_in(rx_in),
        .data_out(data_e), .valid_out(valid_e), .parity_err(perr_e),
        .frame_err(ferr_e), .busy(busy_e)
    );

    parity_frame_rx #(.DATA_W(DW), .CLKS_PER_BIT(C), .ODD_PARITY(1)) dut_odd (
        .clk(clk), .rst(rst), .rx_in(rx_in),
        .data_out(data_o), .valid_out(valid_o), .parity_err(perr_o),
        .frame_err(ferr_o), .busy(busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [DW-1:0] d;
        logic          pe;
        logic          fe;
    } ev_t;

    ev_t q_even[$];
    ev_t q_odd[$];
    ev_t q_exp[$];

    // Record every valid_out pulse of both receivers.
    always @(negedge clk) begin : mon
        ev_t e;
        if (valid_e) begin
            e.cyc = cyc; e.d = data_e; e.pe = perr_e; e.fe = ferr_e;
            q_even.push_back(e);
        end
        if (valid_o) begin
            e.cyc = cyc; e.d = data_o; e.pe = perr_o; e.fe = ferr_o;
            q_odd.push_back(e);
        end
    end

    // Line level k cycles after the start bit begins.
    function automatic logic line_level(input logic [DW-1:0] d, input logic p,
                                        input logic s, input int k);
        int slot;
        slot = k / C;
        if (slot == 0)      return 1'b0;
        if (slot <= DW)     return d[slot-1];
        if (slot == DW + 1) return p;
        if (slot == DW + 2) return s;
        return 1'b1;
    endfunction

    function automatic logic exp_perr(input logic [DW-1:0] d, input logic p, input logic odd);
        return (^d) ^ p ^ odd;
    endfunction

    // Drive the first ncyc cycles of a frame; t = edge at which the DUT
    // first sees the start bit.  Called and returns at posedge+1.
    task automatic drive(input logic [DW-1:0] d, input logic p, input logic s,
                         input int ncyc, output int t);
        t = cyc + 1;
        for (int k = 0; k < ncyc; k++) begin
            rx_in = line_level(d, p, s, k);
            @(posedge clk); #1;
        end
        rx_in = 1'b1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (data_e !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_e); end
        checks++; if (valid_e !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_e); end
        checks++; if (perr_e !== 1'b0 || perr_o !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b/%b exp=0/0", perr_e, perr_o); end
        checks++; if (ferr_e !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", ferr_e); end
        checks++; if (busy_e !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b/%b exp=0/0", busy_e, busy_o); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_clean;
        int t;
        logic exp_busy, exp_valid;
        q_even.delete(); q_odd.delete();
        t = cyc + 1;
        for (int k = 0; k < FRAME; k++) begin
            rx_in = line_level(8'hA5, 1'b0, 1'b1, k);
            @(posedge clk); #1;
            exp_busy  = (k < VALID_OFS);
            exp_valid = (k == VALID_OFS);
            checks++; if (busy_e !== exp_busy) begin failures++; $display("FAIL clean_busy k=%0d got=%b exp=%b", k, busy_e, exp_busy); end
            checks++; if (valid_e !== exp_valid) begin failures++; $display("FAIL clean_valid k=%0d got=%b exp=%b", k, valid_e, exp_valid); end
            if (exp_valid) begin
                checks++; if (data_e !== 8'hA5) begin failures++; $display("FAIL clean_data got=%h exp=a5", data_e); end
                checks++; if (perr_e !== 1'b0 || ferr_e !== 1'b0) begin failures++; $display("FAIL clean_flags got=%b%b exp=00", perr_e, ferr_e); end
                checks++; if (perr_o !== 1'b1) begin failures++; $display("FAIL clean_odd_perr got=%b exp=1", perr_o); end
            end
        end
        rx_in = 1'b1;
        checks++; if (q_even.size() !== 1) begin failures++; $display("FAIL clean_count got=%0d exp=1 (t=%0d)", q_even.size(), t); end
    endtask

    task automatic test_parity;
        logic [DW-1:0] dv [2];
        logic          ep [2];
        int            t  [2];
        dv[0] = 8'h01; ep[0] = 1'b1;
        dv[1] = 8'h03; ep[1] = 1'b0;
        q_even.delete();
        for (int i = 0; i < 2; i++) begin
            drive(dv[i], 1'b0, 1'b1, FRAME, t[i]);
            idle(2);
        end
        checks++;
        if (q_even.size() !== 2) begin
            failures++; $display("FAIL parity_count got=%0d exp=2", q_even.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++; if (q_even[i].cyc !== t[i] + VALID_OFS) begin failures++; $display("FAIL parity_time%0d got=%0d exp=%0d", i, q_even[i].cyc, t[i] + VALID_OFS); end
                checks++; if (q_even[i].d !== dv[i]) begin failures++; $display("FAIL parity_data%0d got=%h exp=%h", i, q_even[i].d, dv[i]); end
                checks++; if (q_even[i].pe !== ep[i] || q_even[i].fe !== 1'b0) begin failures++; $display("FAIL parity_flags%0d got=%b%b exp=%b0", i, q_even[i].pe, q_even[i].fe, ep[i]); end
            end
        end
    endtask

    task automatic test_framing;
        int t;
        q_even.delete();
        drive(8'hFF, 1'b0, 1'b0, FRAME, t);
        idle(10);
        checks++;
        if (q_even.size() !== 1) begin
            failures++; $display("FAIL frame_count got=%0d exp=1", q_even.size());
        end else begin
            checks++; if (q_even[0].d !== 8'hFF) begin failures++; $display("FAIL frame_data got=%h exp=ff", q_even[0].d); end
            checks++; if (q_even[0].fe !== 1'b1) begin failures++; $display("FAIL frame_ferr got=%b exp=1", q_even[0].fe); end
            checks++; if (q_even[0].pe !== 1'b0) begin failures++; $display("FAIL frame_perr got=%b exp=0", q_even[0].pe); end
        end
    endtask

    // Last completed frame was 0xFF, p=0, stop=0.
    task automatic test_glitch;
        logic exp_busy;
        q_even.delete();
        rx_in = 1'b0;
        for (int k = 0; k < H + 2; k++) begin
            @(posedge clk); #1;
            rx_in = 1'b1;
            exp_busy = (k < H);
            checks++; if (busy_e !== exp_busy) begin failures++; $display("FAIL glitch_busy k=%0d got=%b exp=%b", k, busy_e, exp_busy); end
        end
        idle(FRAME);
        checks++; if (q_even.size() !== 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", q_even.size()); end
        checks++; if (data_e !== 8'hFF || perr_e !== 1'b0 || ferr_e !== 1'b1) begin failures++; $display("FAIL glitch_hold got=%h/%b%b exp=ff/01", data_e, perr_e, ferr_e); end
    endtask

    task automatic test_reset_mid;
        int t;
        q_even.delete(); q_odd.delete();
        drive(8'h5A, 1'b0, 1'b1, 4 * C + 2, t);
        rst = 1'b1; rx_in = 1'b1;
        @(posedge clk); #1;
        checks++; if (data_e !== 8'h00 || valid_e !== 1'b0 || perr_e !== 1'b0 || ferr_e !== 1'b0 || busy_e !== 1'b0) begin
            failures++; $display("FAIL rstmid_outputs got=%h/%b%b%b%b exp=00/0000", data_e, valid_e, perr_e, ferr_e, busy_e);
        end
        rst = 1'b0;
        idle(FRAME);
        checks++; if (q_even.size() !== 0) begin failures++; $display("FAIL rstmid_novalid got=%0d exp=0", q_even.size()); end
        drive(8'h3C, 1'b0, 1'b1, FRAME, t);
        idle(2);
        checks++;
        if (q_even.size() !== 1 || q_odd.size() !== 1) begin
            failures++; $display("FAIL rstmid_count got=%0d/%0d exp=1/1", q_even.size(), q_odd.size());
        end else begin
            checks++; if (q_even[0].d !== 8'h3C || q_even[0].cyc !== t + VALID_OFS) begin failures++; $display("FAIL rstmid_data got=%h@%0d exp=3c@%0d", q_even[0].d, q_even[0].cyc, t + VALID_OFS); end
            checks++; if (q_even[0].pe !== 1'b0 || q_odd[0].pe !== 1'b1) begin failures++; $display("FAIL rstmid_perr got=%b/%b exp=0/1", q_even[0].pe, q_odd[0].pe); end
        end
    endtask

    task automatic test_back_to_back;
        int t1, t2;
        q_odd.delete();
        drive(8'h80, 1'b0, 1'b1, FRAME, t1);
        drive(8'h7F, 1'b0, 1'b1, FRAME, t2);
        idle(2);
        checks++;
        if (q_odd.size() !== 2) begin
            failures++; $display("FAIL b2b_count got=%0d exp=2", q_odd.size());
        end else begin
            checks++; if (q_odd[1].cyc - q_odd[0].cyc !== FRAME) begin failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", q_odd[1].cyc - q_odd[0].cyc, FRAME); end
            checks++; if (q_odd[0].cyc !== t1 + VALID_OFS) begin failures++; $display("FAIL b2b_time got=%0d exp=%0d", q_odd[0].cyc, t1 + VALID_OFS); end
            checks++; if (q_odd[0].d !== 8'h80 || q_odd[1].d !== 8'h7F) begin failures++; $display("FAIL b2b_data got=%h,%h exp=80,7f", q_odd[0].d, q_odd[1].d); end
            checks++; if (q_odd[0].pe !== 1'b0 || q_odd[1].pe !== 1'b0) begin failures++; $display("FAIL b2b_perr got=%b,%b exp=0,0", q_odd[0].pe, q_odd[1].pe); end
        end
    endtask

    task automatic test_random;
        ev_t e;
        logic [DW-1:0] d;
        logic p, s;
        int t, gap;
        q_even.delete(); q_odd.delete(); q_exp.delete();
        for (int n = 0; n < 24; n++) begin
            d = DW'($urandom);
            p = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 3) != 0);
            drive(d, p, s, FRAME, t);
            e.cyc = t + VALID_OFS; e.d = d; e.pe = exp_perr(d, p, 1'b0); e.fe = ~s;
            q_exp.push_back(e);
            // A low stop bit looks like a new start; give the line time to
            // settle so the next frame is not swallowed by that false start.
            gap = s ? int'($urandom_range(0, 3)) : C + int'($urandom_range(0, 3));
            idle(gap);
        end
        idle(2);
        checks++;
        if (q_even.size() !== q_exp.size() || q_odd.size() !== q_exp.size()) begin
            failures++; $display("FAIL rand_count got=%0d/%0d exp=%0d", q_even.size(), q_odd.size(), q_exp.size());
        end else begin
            for (int i = 0; i < q_exp.size(); i++) begin
                checks++;
                if (q_even[i].cyc !== q_exp[i].cyc || q_even[i].d !== q_exp[i].d ||
                    q_even[i].pe !== q_exp[i].pe || q_even[i].fe !== q_exp[i].fe) begin
                    failures++;
                    $display("FAIL rand_even%0d got=%h/%b%b@%0d exp=%h/%b%b@%0d", i,
                             q_even[i].d, q_even[i].pe, q_even[i].fe, q_even[i].cyc,
                             q_exp[i].d, q_exp[i].pe, q_exp[i].fe, q_exp[i].cyc);
                end
                checks++;
                if (q_odd[i].d !== q_exp[i].d || q_odd[i].pe !== ~q_exp[i].pe || q_odd[i].fe !== q_exp[i].fe) begin
                    failures++;
                    $display("FAIL rand_odd%0d got=%h/%b%b exp=%h/%b%b", i,
                             q_odd[i].d, q_odd[i].pe, q_odd[i].fe,
                             q_exp[i].d, ~q_exp[i].pe, q_exp[i].fe);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_parity();
        test_framing();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
